// File: rtl/rx_alu_sequencer.sv
// rx_alu_sequencer
// Multi-cycle ALU command sequencer driving a single-port register file.
// A command is accepted in IDLE, source registers are read one per cycle
// through the shared rf_nr address, the ALU result is registered in EXEC and
// written back (except for CMP) in WB, where done pulses for one cycle.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op                0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 MOV,6 LDI,7 CMP
//   cmd_rd/rs1/rs2        destination and source register numbers
//   cmd_imm               LDI immediate
//   rf_wr/rf_nr/rf_wdata  register file write enable, shared address, write data
//   rf_rdata              register file read data (combinational from rf_nr)
//   done                  one-cycle completion pulse
//   result                registered result of the last executed command
//   flag_c, flag_z        carry/borrow and zero flags
module rx_alu_sequencer #(
  parameter int RX_COUNT = 8,
  parameter int RX_WIDTH = 8,
  localparam int AW = (RX_COUNT > 1) ? $clog2(RX_COUNT) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [AW-1:0]       cmd_rd,
  input  logic [AW-1:0]       cmd_rs1,
  input  logic [AW-1:0]       cmd_rs2,
  input  logic [RX_WIDTH-1:0] cmd_imm,
  output logic                rf_wr,
  output logic [AW-1:0]       rf_nr,
  output logic [RX_WIDTH-1:0] rf_wdata,
  input  logic [RX_WIDTH-1:0] rf_rdata,
  output logic                done,
  output logic [RX_WIDTH-1:0] result,
  output logic                flag_c,
  output logic                flag_z
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_LDI = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB} state_t;

  state_t              state;
  logic [2:0]          op_q;
  logic [AW-1:0]       rd_q;
  logic [AW-1:0]       rs2_q;
  logic [RX_WIDTH-1:0] imm_q;
  logic [RX_WIDTH-1:0] op_a;
  logic [RX_WIDTH-1:0] op_b;
  logic [RX_WIDTH:0]   alu_out;

  // Returns {carry, value}. The extra top bit of an unsigned subtraction is
  // exactly the borrow (A < B). MOV/LDI pass the current carry through.
  function automatic logic [RX_WIDTH:0] alu(input logic [2:0]          op,
                                            input logic [RX_WIDTH-1:0] a,
                                            input logic [RX_WIDTH-1:0] b,
                                            input logic [RX_WIDTH-1:0] imm,
                                            input logic                c_in);
    logic [RX_WIDTH:0] r;
    r = '0;
    case (op)
      OP_ADD:         r = {1'b0, a} + {1'b0, b};
      OP_SUB, OP_CMP: r = {1'b0, a} - {1'b0, b};
      OP_AND:         r = {1'b0, a & b};
      OP_OR:          r = {1'b0, a | b};
      OP_XOR:         r = {1'b0, a ^ b};
      OP_MOV:         r = {c_in, a};
      OP_LDI:         r = {c_in, imm};
      default:        r = '0;
    endcase
    return r;
  endfunction

  assign alu_out  = alu(op_q, op_a, op_b, imm_q, flag_c);
  assign rf_wdata = result;

  // Outputs are registered alongside the state, so each one is set up for
  // the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rf_wr     <= 1'b0;
      rf_nr     <= '0;
      done      <= 1'b0;
      result    <= '0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
    end else begin
      case (state)
        // IDLE: accept and latch the command; rs1 goes straight onto rf_nr
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            rd_q      <= cmd_rd;
            rs2_q     <= cmd_rs2;
            imm_q     <= cmd_imm;
            cmd_ready <= 1'b0;
            if (cmd_op == OP_LDI) begin
              state <= EXEC;
              rf_nr <= '0;
            end else begin
              state <= RD_A;
              rf_nr <= cmd_rs1;
            end
          end
        end
        // RD_A: capture operand A; MOV needs no second operand
        RD_A: begin
          op_a <= rf_rdata;
          if (op_q == OP_MOV) begin
            state <= EXEC;
            rf_nr <= '0;
          end else begin
            state <= RD_B;
            rf_nr <= rs2_q;
          end
        end
        // RD_B: capture operand B
        RD_B: begin
          op_b  <= rf_rdata;
          state <= EXEC;
          rf_nr <= '0;
        end
        // EXEC: register result and flags, then present the write-back
        EXEC: begin
          result <= alu_out[RX_WIDTH-1:0];
          flag_c <= alu_out[RX_WIDTH];
          flag_z <= (alu_out[RX_WIDTH-1:0] == '0);
          state  <= WB;
          done   <= 1'b1;
          rf_nr  <= rd_q;
          rf_wr  <= (op_q != OP_CMP);
        end
        // WB: write lands on this edge; return to IDLE
        WB: begin
          state     <= IDLE;
          done      <= 1'b0;
          rf_wr     <= 1'b0;
          rf_nr     <= '0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          done      <= 1'b0;
          rf_wr     <= 1'b0;
          rf_nr     <= '0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_alu_sequencer.sv
module tb_rx_alu_sequencer;
  localparam int N   = 8;
  localparam int W   = 8;
  localparam int AW  = 3;
  localparam int MOD = 1 << W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [AW-1:0] cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic [W-1:0]  cmd_imm = '0;
  logic          rf_wr;
  logic [AW-1:0] rf_nr;
  logic [W-1:0]  rf_wdata, rf_rdata;
  logic          done;
  logic [W-1:0]  result;
  logic          flag_c, flag_z;

  int checks = 0;
  int errors = 0;

  // attached register file
  logic [W-1:0] rf [N] = '{default: '0};
  always @(posedge clk) if (rf_wr) rf[rf_nr] <= rf_wdata;
  assign rf_rdata = rf[rf_nr];

  // reference model state
  int ref_rf [N] = '{default: 0};
  int ref_res = 0;
  bit ref_c = 1'b0;
  bit ref_z = 1'b0;

  rx_alu_sequencer #(.RX_COUNT(N), .RX_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_imm(cmd_imm), .rf_wr(rf_wr), .rf_nr(rf_nr), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata), .done(done), .result(result), .flag_c(flag_c),
    .flag_z(flag_z)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(int op);
    if (op == 6) return 2;
    if (op == 5) return 3;
    return 4;
  endfunction

  function automatic void model(int op, int rd, int rs1, int rs2, int imm);
    int a, b, r;
    a = ref_rf[rs1];
    b = ref_rf[rs2];
    r = 0;
    case (op)
      0: begin r = a + b; ref_c = (r >= MOD); r = r % MOD; end
      1, 7: begin ref_c = (a < b); r = (a - b + MOD) % MOD; end
      2: begin r = a & b; ref_c = 1'b0; end
      3: begin r = a | b; ref_c = 1'b0; end
      4: begin r = a ^ b; ref_c = 1'b0; end
      5: r = a;
      6: r = imm;
      default: r = 0;
    endcase
    ref_res = r;
    ref_z = (r == 0);
    if (op != 7) ref_rf[rd] = r;
  endfunction

  task automatic check_rf(input string tag);
    int bad = 0;
    int bi = 0;
    for (int i = 0; i < N; i++)
      if (rf[i] !== ref_rf[i][W-1:0]) begin
        if (bad == 0) bi = i;
        bad++;
      end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s rf: R%0d actual %h required %h (%0d regs differ)",
               tag, bi, rf[bi], ref_rf[bi][W-1:0], bad);
    end
  endtask

  task automatic run_cmd(input int op, input int rd, input int rs1,
                         input int rs2, input int imm, input string tag);
    int got = 0;
    int wr_cnt = 0;
    int wr_bad = 0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before: actual %b required 1", tag, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op  = op[2:0];
    cmd_rd  = rd[AW-1:0];
    cmd_rs1 = rs1[AW-1:0];
    cmd_rs2 = rs2[AW-1:0];
    cmd_imm = imm[W-1:0];
    model(op, rd, rs1, rs2, imm);
    @(posedge clk);
    #1;
    for (int n = 1; n <= 10; n++) begin
      // command inputs change while busy and must be ignored
      cmd_op  = 3'($urandom);
      cmd_rd  = AW'($urandom);
      cmd_rs1 = AW'($urandom);
      cmd_rs2 = AW'($urandom);
      cmd_imm = W'($urandom);
      @(negedge clk);
      if (rf_wr === 1'b1) wr_cnt++;
      if (rf_wr === 1'b1 && done !== 1'b1) wr_bad++;
      if (done === 1'b1) begin
        got = n;
        break;
      end
    end
    checks++;
    if (got != lat_of(op)) begin
      errors++;
      $display("FAIL %s latency: actual %0d required %0d", tag, got, lat_of(op));
    end
    checks++;
    if (result !== ref_res[W-1:0]) begin
      errors++;
      $display("FAIL %s result: actual %h required %h", tag, result, ref_res[W-1:0]);
    end
    checks++;
    if (flag_c !== ref_c || flag_z !== ref_z) begin
      errors++;
      $display("FAIL %s flags c/z: actual %b%b required %b%b", tag, flag_c, flag_z, ref_c, ref_z);
    end
    checks++;
    if (wr_cnt != ((op == 7) ? 0 : 1) || wr_bad != 0) begin
      errors++;
      $display("FAIL %s rf_wr: actual %0d writes (%0d outside WB) required %0d",
               tag, wr_cnt, wr_bad, (op == 7) ? 0 : 1);
    end
    if (op != 7) begin
      checks++;
      if (rf_nr !== rd[AW-1:0]) begin
        errors++;
        $display("FAIL %s wb_addr: actual %0d required %0d", tag, rf_nr, rd);
      end
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done ready/done: actual %b/%b required 1/0", tag, cmd_ready, done);
    end
    check_rf(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (cmd_ready !== 1'b1 || rf_wr !== 1'b0 || rf_nr !== '0 || done !== 1'b0 ||
        result !== '0 || flag_c !== 1'b0 || flag_z !== 1'b0) begin
      errors++;
      $display("FAIL %s outputs rdy/wr/nr/done/res/c/z: actual %b/%b/%0d/%b/%h/%b/%b required 1/0/0/0/00/0/0",
               tag, cmd_ready, rf_wr, rf_nr, done, result, flag_c, flag_z);
    end
  endtask

  task automatic test_reset();
    // a command offered during reset must not be accepted
    rst = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 3'd6;
    cmd_rd = 3'd1;
    cmd_imm = 8'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    cmd_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_idle");
    check_rf("reset");
  endtask

  task automatic test_directed();
    run_cmd(6, 1, 0, 0, 8'h05, "ldi_r1");
    run_cmd(6, 2, 0, 0, 8'h03, "ldi_r2");
    run_cmd(6, 1, 0, 0, 8'hF0, "ldi_f0");
    run_cmd(6, 2, 0, 0, 8'h20, "ldi_20");
    run_cmd(0, 3, 1, 2, 0, "add_carry");
    run_cmd(6, 1, 0, 0, 8'h07, "ldi_7a");
    run_cmd(6, 2, 0, 0, 8'h07, "ldi_7b");
    run_cmd(7, 3, 1, 2, 0, "cmp_equal");
    run_cmd(6, 2, 0, 0, 8'h03, "ldi_3");
    run_cmd(6, 1, 0, 0, 8'h05, "ldi_5");
    run_cmd(1, 4, 2, 1, 0, "sub_borrow");
    run_cmd(5, 5, 4, 0, 0, "mov_keep_c");
    run_cmd(6, 1, 0, 0, 8'h40, "ldi_40");
    run_cmd(0, 1, 1, 1, 0, "add_alias");
    run_cmd(6, 0, 0, 0, 8'h00, "ldi_zero");
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 3'd0;
    cmd_rd = 3'd6;
    cmd_rs1 = 3'd1;
    cmd_rs2 = 3'd2;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);                 // RD_A
    if (done === 1'b1 || rf_wr === 1'b1) bad++;
    @(negedge clk);                 // RD_B
    if (done === 1'b1 || rf_wr === 1'b1) bad++;
    rst = 1'b1;
    @(negedge clk);
    ref_res = 0;
    ref_c = 1'b0;
    ref_z = 1'b0;
    check_reset_outputs("reset_mid");
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1 || rf_wr === 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid stray done/write: actual %0d cycles required 0", bad);
    end
    check_rf("reset_mid");
    run_cmd(0, 6, 1, 2, 0, "after_abort");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, N - 1)),
              int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)),
              int'($urandom_range(0, MOD - 1)), "random");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_alu_sequencer.md
RX_ALU_SEQUENCER -- requirements
Module: rx_alu_sequencer

Interface
REQ-001 The block SHALL have parameter RX_COUNT, default 8, giving the number of registers in the attached single-port register file.
REQ-002 The block SHALL have parameter RX_WIDTH, default 8, giving the register data width.
REQ-003 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid  in  1  command present.
REQ-006 cmd_ready  out  1  block can accept a command.
REQ-007 cmd_op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV, 6 LDI, 7 CMP.
REQ-008 cmd_rd, cmd_rs1, cmd_rs2  in  $clog2(RX_COUNT) each  destination and source register numbers.
REQ-009 cmd_imm  in  RX_WIDTH  immediate value for LDI.
REQ-010 rf_wr  out  1  register file write enable.
REQ-011 rf_nr  out  $clog2(RX_COUNT)  register file address (shared by read and write).
REQ-012 rf_wdata  out  RX_WIDTH  register file write data.
REQ-013 rf_rdata  in  RX_WIDTH  register file read data, combinational from rf_nr.
REQ-014 done  out  1  one-cycle pulse marking command completion.
REQ-015 result  out  RX_WIDTH  registered result of the last executed command.
REQ-016 flag_c, flag_z  out  1 each  carry/borrow and zero flags.

Function
REQ-017 FSM states SHALL be IDLE, RD_A, RD_B, EXEC, WB; cmd_ready SHALL be 1 only in IDLE.
REQ-018 A command SHALL be accepted on a rising edge in IDLE with cmd_valid=1; op, rd, rs2 and imm SHALL be latched at acceptance; cmd_* inputs SHALL be ignored outside IDLE.
REQ-019 Transitions: ADD/SUB/AND/OR/XOR/CMP IDLE->RD_A->RD_B->EXEC->WB->IDLE; MOV IDLE->RD_A->EXEC->WB->IDLE; LDI IDLE->EXEC->WB->IDLE.
REQ-020 RD_A: rf_nr=latched rs1, rf_wr=0, and rf_rdata SHALL be captured into operand A at the end of the cycle; RD_B does the same with rs2 into operand B.
REQ-021 EXEC: result and flags SHALL be registered at the end of the cycle; rf_wr=0.
REQ-022 Arithmetic SHALL be modulo 2^RX_WIDTH. ADD: flag_c = carry out. SUB/CMP: A-B, flag_c=1 iff A<B unsigned. AND/OR/XOR: flag_c=0. MOV: result=A. LDI: result=imm.
REQ-023 flag_z SHALL be set to (result==0) for every op; MOV and LDI SHALL leave flag_c unchanged.
REQ-024 WB: done=1 for exactly this cycle; rf_nr=latched rd, and rf_wr=1 for every op except CMP, for which rf_wr=0 and the register file is unchanged.
REQ-025 rf_wdata SHALL equal result at all times; rf_nr SHALL be 0 in IDLE and EXEC.
REQ-026 Latency from acceptance at edge k: two-operand ops SHALL assert done in cycle k+4, MOV in k+3, LDI in k+2; cmd_ready SHALL return to 1 in the following cycle.
REQ-027 rd equal to rs1 or rs2 SHALL require no special handling, because all reads complete before WB.

Reset
REQ-028 rst=1 at any state SHALL force IDLE on the next edge with cmd_ready=1, rf_wr=0, rf_nr=0, done=0, result=0, flag_c=0, flag_z=0.
REQ-029 Reset mid-operation SHALL abort the command without any register write and without a done pulse.
REQ-030 rst SHALL take priority over a simultaneous cmd_valid; no command SHALL be accepted while rst=1.

Verification
REQ-031 LDI R1,0x05 then LDI R2,0x03 -> done 2 cycles after each acceptance; R1=0x05, R2=0x03; flag_z=0.
REQ-032 ADD R3,R1,R2 with R1=0xF0, R2=0x20 -> R3=0x10, flag_c=1, flag_z=0, done in k+4, rf_wr high only in WB.
REQ-033 CMP R1,R2 with R1=R2=0x07 -> flag_z=1, flag_c=0, rf_wr never asserted, R1 and R2 unchanged.
REQ-034 SUB R4,R2,R1 with R2=0x03, R1=0x05 -> R4=0xFE, flag_c=1; then MOV R5,R4 -> R5=0xFE, flag_c still 1.
REQ-035 ADD R1,R1,R1 with R1=0x40 -> R1=0x80 (rd aliases both sources).
REQ-036 rst pulsed during RD_B of ADD R6 -> no write to R6, no done pulse, all outputs at reset values, next command accepted normally.
